bfu_golden_checker: RTL and testbench
=====================================

# bfu_golden_checker

Parametrised, self-checking golden model for the NTT butterfly datapath. It is the successor to the single-lane fixed-latency BFU golden model. It computes reference results for `LANES` parallel butterflies with a configurable modulus width and pipeline depth, and delays those results to line up with the DUT. It follows DUT stalls, compares every lane against the DUT outputs, and keeps error statistics. It sits in the testbench beside the two-BFU NTT core.

## Interface
- `DW`, 32: operand/modulus width.
- `LANES`, 2: parallel butterfly lanes; lane k occupies bits `[k*DW +: DW]`.
- `LATENCY`, 8: DUT pipeline depth in enabled cycles; must be ≥ 1.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk`  in  1  clock.
- `rstn`  in  1  reset: asynchronous, active-low.
- `en`  in  1  pipeline advance; low freezes the delay line, matching the DUT stall.
- `clr`  in  1  synchronous clear of counters and sticky flags.
- `in_valid`  in  1  input transaction present.
- `op`  in  2  shared by all lanes: 00 CT, 01 GS, 10 MM, 11 AS.
- `in1`, `in2`, `gamma`  in  LANES*DW  per-lane operands.
- `p`, `R_1`  in  DW  modulus and Montgomery inverse factor, shared by all lanes.
- `dut_valid`  in  1  DUT output valid.
- `dut_out1`, `dut_out2`  in  LANES*DW  DUT results.
- `gold_valid`  out  1  golden result valid.
- `gold_out1`, `gold_out2`  out  LANES*DW  golden results.
- `mismatch`  out  1  registered one-cycle pulse.
- `mismatch_lane`  out  LANES  lanes that failed in the flagged compare.
- `proto_err`  out  1  sticky flag; set on a valid misalignment.
- `chk_cnt`, `err_cnt`  out  CNT_W  number of compares and number of failed compares; both saturate.
- `first_err_idx`  out  CNT_W  value of `chk_cnt` at the first failure.
- `first_err_op`  out  2  `op` of the first failing transaction.

## Operation
Per lane, with a = in1, b = in2, w = gamma and t = (b·w·R_1) mod p:
- CT: out1 = (a+t) mod p; out2 = (a−t+p) mod p.
- GS: out1 = (a+b) mod p; out2 = (((b−a+p) mod p)·w·R_1) mod p.
- MM: out1 = (a·b·R_1) mod p; out2 = 0.
- AS: out1 = (a+b) mod p; out2 = (b−a+p) mod p.

Width and range rules:
- Products are formed at 3·DW bits; sums and differences at DW+2 bits; results are truncated to DW bits after the reduction.
- The operands a and b are required to be < p. Behaviour outside that range is unspecified, but must not produce X.

Pipeline and statistics:
- The delay line is `LATENCY` deep and carries valid, op, out1 and out2. It shifts only when `en`=1.
- Compare happens when `gold_valid`=1 and `en`=1: every lane, both outputs.
  - `chk_cnt` increments.
  - On any lane difference: `err_cnt` increments and the mismatch outputs register. On the first failure since reset or `clr`, `first_err_idx` and `first_err_op` are captured.
- When `en`=1 and `dut_valid` ≠ `gold_valid`, `proto_err` sets and no data compare happens.
- `clr` zeroes the counters, `proto_err` and the first-error registers. It does not touch the delay line. If `clr` coincides with a compare, `clr` wins: the counters read 0 afterwards, but the `mismatch` pulse still fires.
- Counters saturate at 2^CNT_W−1.

## Timing
- Reset values: all outputs are 0, and every delay-line stage is cleared.
- Latency: a transaction sampled with `in_valid`=1 on enabled edge n appears on `gold_*` after enabled edge n+LATENCY−1. This is exactly `LATENCY` enabled cycles, and stalled cycles do not count.
- `mismatch`, `mismatch_lane` and the counters update one clock after the compare cycle.
- `gold_*` hold their value while `en`=0.
- If reset asserts mid-stream, all in-flight transactions are discarded.

## Structure
- Package `bfu_pkg`:
  - op constants `OP_CT`, `OP_GS`, `OP_MM`, `OP_AS`;
  - a struct for one delay-line stage entry (valid, op, out1, out2).
- Sub-module `bfu_golden_lane`: the combinational per-lane arithmetic, parametrised by `DW` and instantiated `LANES` times.
- The top level holds the delay line, the compare logic and the statistics.

## Test plan
All scenarios use p=17, `LATENCY`=8 and `en`=1 unless stated otherwise.
- CT with R_1=1, in1=3, in2=5, gamma=2, DUT echoing the golden values: out1=13, out2=10 appear 8 cycles later; `chk_cnt`=1, `err_cnt`=0.
- GS 3/5/2 → 8, 4; MM 4/5 → 3, 0; AS 10/3 → 13, 10. Issue one op per cycle, back to back; all four emerge in order on consecutive cycles.
- Montgomery case R_1=9, CT in1=0, in2=1, gamma=2: out1=1, out2=16.
- DUT lane 1 out2 forced wrong on the 3rd transaction: `mismatch`=1 with `mismatch_lane`=2'b10, `err_cnt`=1, `first_err_idx`=2. A second error leaves `first_err_idx` unchanged.
- `en` held low for 5 cycles mid-stream: output is delayed by exactly 5 cycles and no compares happen while stalled. Then `dut_valid` one cycle early: `proto_err` sets and stays set until `clr`.
- `clr` in the same cycle as a failing compare: counters read 0 afterwards and the `mismatch` pulse is still seen. `rstn` pulsed with 4 transactions in flight: no `gold_valid` follows.

Source files
------------

// File: rtl/bfu_pkg.sv
// Shared definitions for the BFU golden checker: butterfly opcodes and the
// control header carried by every delay-line stage.
package bfu_pkg;

  typedef enum logic [1:0] {
    OP_CT = 2'b00,
    OP_GS = 2'b01,
    OP_MM = 2'b10,
    OP_AS = 2'b11
  } bfu_op_e;

  // Control part of one delay-line entry; the top level wraps it with the
  // lane-width-dependent out1/out2 payload.
  typedef struct packed {
    logic    valid;
    bfu_op_e op;
  } bfu_stage_hdr_t;

endpackage

// File: rtl/bfu_golden_lane.sv
// Combinational reference arithmetic for one butterfly lane (CT/GS/MM/AS).
module bfu_golden_lane
  import bfu_pkg::*;
#(
  parameter int DW = 32
) (
  input  bfu_op_e       op_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [DW-1:0] w_i,
  input  logic [DW-1:0] p_i,
  input  logic [DW-1:0] r1_i,
  output logic [DW-1:0] out1_o,
  output logic [DW-1:0] out2_o
);

  localparam int PW = 3 * DW;
  localparam int SW = DW + 2;

  // (x*y*z) mod m with the full 3*DW product; a zero modulus yields 0 so
  // nothing downstream ever sees X.
  function automatic logic [DW-1:0] mod_prod3(input logic [DW-1:0] x,
                                              input logic [DW-1:0] y,
                                              input logic [DW-1:0] z,
                                              input logic [DW-1:0] m);
    logic [PW-1:0] prod;
    prod = PW'(x) * PW'(y) * PW'(z);
    if (m == '0) return '0;
    return DW'(prod % PW'(m));
  endfunction

  function automatic logic [DW-1:0] mod_sum(input logic [SW-1:0] x,
                                            input logic [DW-1:0] m);
    if (m == '0) return '0;
    return DW'(x % SW'(m));
  endfunction

  logic [DW-1:0] t_mont;
  logic [DW-1:0] add_ab;
  logic [DW-1:0] sub_ba;

  always_comb begin
    t_mont = mod_prod3(b_i, w_i, r1_i, p_i);
    add_ab = mod_sum(SW'(a_i) + SW'(b_i), p_i);
    sub_ba = mod_sum(SW'(b_i) + SW'(p_i) - SW'(a_i), p_i);
    out1_o = '0;
    out2_o = '0;
    case (op_i)
      OP_CT: begin
        out1_o = mod_sum(SW'(a_i) + SW'(t_mont), p_i);
        out2_o = mod_sum(SW'(a_i) + SW'(p_i) - SW'(t_mont), p_i);
      end
      OP_GS: begin
        out1_o = add_ab;
        out2_o = mod_prod3(sub_ba, w_i, r1_i, p_i);
      end
      OP_MM: begin
        out1_o = mod_prod3(a_i, b_i, r1_i, p_i);
        out2_o = '0;
      end
      OP_AS: begin
        out1_o = add_ab;
        out2_o = sub_ba;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bfu_golden_checker.sv
// Multi-lane BFU golden model: computes reference butterflies, delays them to
// line up with the DUT pipeline, compares every lane and keeps statistics.
module bfu_golden_checker
  import bfu_pkg::*;
#(
  parameter int DW      = 32,
  parameter int LANES   = 2,
  parameter int LATENCY = 8,   // must be >= 1
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic                clr,
  input  logic                in_valid,
  input  logic [1:0]          op,
  input  logic [LANES*DW-1:0] in1,
  input  logic [LANES*DW-1:0] in2,
  input  logic [LANES*DW-1:0] gamma,
  input  logic [DW-1:0]       p,
  input  logic [DW-1:0]       R_1,
  input  logic                dut_valid,
  input  logic [LANES*DW-1:0] dut_out1,
  input  logic [LANES*DW-1:0] dut_out2,
  output logic                gold_valid,
  output logic [LANES*DW-1:0] gold_out1,
  output logic [LANES*DW-1:0] gold_out2,
  output logic                mismatch,
  output logic [LANES-1:0]    mismatch_lane,
  output logic                proto_err,
  output logic [CNT_W-1:0]    chk_cnt,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [CNT_W-1:0]    first_err_idx,
  output logic [1:0]          first_err_op
);

  localparam int BW = LANES * DW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    bfu_stage_hdr_t hdr;
    logic [BW-1:0]  out1;
    logic [BW-1:0]  out2;
  } stage_t;

  logic [BW-1:0] calc1;
  logic [BW-1:0] calc2;
  stage_t        stage_d;
  stage_t        pipe_q [LATENCY];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    bfu_golden_lane #(.DW(DW)) u_lane (
      .op_i   (bfu_op_e'(op)),
      .a_i    (in1[k*DW +: DW]),
      .b_i    (in2[k*DW +: DW]),
      .w_i    (gamma[k*DW +: DW]),
      .p_i    (p),
      .r1_i   (R_1),
      .out1_o (calc1[k*DW +: DW]),
      .out2_o (calc2[k*DW +: DW])
    );
  end

  always_comb begin
    stage_d.hdr.valid = in_valid;
    stage_d.hdr.op    = bfu_op_e'(op);
    stage_d.out1      = calc1;
    stage_d.out2      = calc2;
  end

  // Delay line advances only on enabled cycles, mirroring the DUT stall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else if (en) begin
      pipe_q[0] <= stage_d;
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign gold_valid = pipe_q[LATENCY-1].hdr.valid;
  assign gold_out1  = pipe_q[LATENCY-1].out1;
  assign gold_out2  = pipe_q[LATENCY-1].out2;

  logic             do_cmp;
  logic             proto_hit;
  logic             any_diff;
  logic [LANES-1:0] lane_diff;

  always_comb begin
    lane_diff = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_diff[k] = (gold_out1[k*DW +: DW] != dut_out1[k*DW +: DW]) ||
                     (gold_out2[k*DW +: DW] != dut_out2[k*DW +: DW]);
    end
    any_diff  = |lane_diff;
    proto_hit = en && (dut_valid != gold_valid);
    do_cmp    = en && gold_valid && dut_valid;
  end

  logic             mismatch_q,      mismatch_d;
  logic [LANES-1:0] mismatch_lane_q, mismatch_lane_d;
  logic             proto_err_q,     proto_err_d;
  logic [CNT_W-1:0] chk_cnt_q,       chk_cnt_d;
  logic [CNT_W-1:0] err_cnt_q,       err_cnt_d;
  logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
  bfu_op_e          first_err_op_q,  first_err_op_d;

  // err_cnt never returns to zero except through reset or clr, so a zero
  // count marks "no failure captured yet".
  always_comb begin
    mismatch_d      = do_cmp && any_diff;
    mismatch_lane_d = (do_cmp && any_diff) ? lane_diff : '0;
    proto_err_d     = proto_err_q || proto_hit;
    chk_cnt_d       = chk_cnt_q;
    err_cnt_d       = err_cnt_q;
    first_err_idx_d = first_err_idx_q;
    first_err_op_d  = first_err_op_q;
    if (do_cmp) begin
      if (chk_cnt_q != CNT_MAX) chk_cnt_d = chk_cnt_q + CNT_W'(1);
      if (any_diff) begin
        if (err_cnt_q == '0) begin
          first_err_idx_d = chk_cnt_q;
          first_err_op_d  = pipe_q[LATENCY-1].hdr.op;
        end
        if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
    // clr overrides the statistics but leaves the mismatch pulse alone.
    if (clr) begin
      proto_err_d     = 1'b0;
      chk_cnt_d       = '0;
      err_cnt_d       = '0;
      first_err_idx_d = '0;
      first_err_op_d  = OP_CT;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mismatch_q      <= 1'b0;
      mismatch_lane_q <= '0;
      proto_err_q     <= 1'b0;
      chk_cnt_q       <= '0;
      err_cnt_q       <= '0;
      first_err_idx_q <= '0;
      first_err_op_q  <= OP_CT;
    end else begin
      mismatch_q      <= mismatch_d;
      mismatch_lane_q <= mismatch_lane_d;
      proto_err_q     <= proto_err_d;
      chk_cnt_q       <= chk_cnt_d;
      err_cnt_q       <= err_cnt_d;
      first_err_idx_q <= first_err_idx_d;
      first_err_op_q  <= first_err_op_d;
    end
  end

  assign mismatch      = mismatch_q;
  assign mismatch_lane = mismatch_lane_q;
  assign proto_err     = proto_err_q;
  assign chk_cnt       = chk_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_err_idx_q;
  assign first_err_op  = first_err_op_q;

endmodule

// File: tb/tb_bfu_golden_checker.sv
// Directed bench for bfu_golden_checker: p=17, LATENCY=8, two lanes, 4-bit
// counters so saturation is reachable quickly.
module tb_bfu_golden_checker;

  localparam int DW      = 32;
  localparam int LANES   = 2;
  localparam int LATENCY = 8;
  localparam int CNT_W   = 4;
  localparam int BW      = LANES * DW;
  localparam int NVEC    = 5;

  logic             clk = 1'b0;
  logic             rstn;
  logic             en;
  logic             clr;
  logic             in_valid;
  logic [1:0]       op;
  logic [BW-1:0]    in1, in2, gamma;
  logic [DW-1:0]    p, R_1;
  logic             dut_valid;
  logic [BW-1:0]    dut_out1, dut_out2;
  logic             gold_valid;
  logic [BW-1:0]    gold_out1, gold_out2;
  logic             mismatch;
  logic [LANES-1:0] mismatch_lane;
  logic             proto_err;
  logic [CNT_W-1:0] chk_cnt, err_cnt, first_err_idx;
  logic [1:0]       first_err_op;

  int vectors     = 0;
  int miscompares = 0;

  logic [1:0]    t_op   [NVEC];
  logic [BW-1:0] t_in1  [NVEC];
  logic [BW-1:0] t_in2  [NVEC];
  logic [BW-1:0] t_gam  [NVEC];
  logic [BW-1:0] t_e1   [NVEC];
  logic [BW-1:0] t_e2   [NVEC];

  always #5 clk = ~clk;

  bfu_golden_checker #(
    .DW(DW), .LANES(LANES), .LATENCY(LATENCY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr),
    .in_valid(in_valid), .op(op), .in1(in1), .in2(in2), .gamma(gamma),
    .p(p), .R_1(R_1),
    .dut_valid(dut_valid), .dut_out1(dut_out1), .dut_out2(dut_out2),
    .gold_valid(gold_valid), .gold_out1(gold_out1), .gold_out2(gold_out2),
    .mismatch(mismatch), .mismatch_lane(mismatch_lane), .proto_err(proto_err),
    .chk_cnt(chk_cnt), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx), .first_err_op(first_err_op)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input logic [1:0] o,
                      input int a0, input int b0, input int w0,
                      input int a1, input int b1, input int w1,
                      input int e10, input int e20, input int e11, input int e21);
    t_op[i]  = o;
    t_in1[i] = {DW'(a1), DW'(a0)};
    t_in2[i] = {DW'(b1), DW'(b0)};
    t_gam[i] = {DW'(w1), DW'(w0)};
    t_e1[i]  = {DW'(e11), DW'(e10)};
    t_e2[i]  = {DW'(e21), DW'(e20)};
  endtask

  task automatic drive_in(input int i);
    in_valid = 1'b1;
    op       = t_op[i];
    in1      = t_in1[i];
    in2      = t_in2[i];
    gamma    = t_gam[i];
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    op       = 2'b00;
    in1      = '0;
    in2      = '0;
    gamma    = '0;
  endtask

  task automatic drive_dut(input logic v, input logic [BW-1:0] o1, input logic [BW-1:0] o2);
    dut_valid = v;
    dut_out1  = o1;
    dut_out2  = o2;
  endtask

  // Issues n back-to-back transactions from the table, then plays the DUT:
  // echoes the expected results, corrupting out2 of transaction 'bad' in the
  // lanes given by bad_mask.
  task automatic burst(input int first, input int n, input int bad, input logic [LANES-1:0] bad_mask);
    logic [BW-1:0]    o2;
    logic [LANES-1:0] exp_lane;
    for (int i = 0; i < n; i++) begin
      drive_in(first + i);
      tick();
    end
    idle_in();
    repeat (LATENCY - 1 - n) tick();
    check("gold_not_early", BW'(gold_valid), BW'(0));
    tick();
    for (int i = 0; i < n; i++) begin
      check("gold_valid", BW'(gold_valid), BW'(1));
      check("gold_out1", gold_out1, t_e1[first + i]);
      check("gold_out2", gold_out2, t_e2[first + i]);
      exp_lane = (i > 0 && i - 1 == bad) ? bad_mask : '0;
      check("mismatch_lane", BW'(mismatch_lane), BW'(exp_lane));
      check("mismatch", BW'(mismatch), BW'(exp_lane != '0));
      o2 = t_e2[first + i];
      if (i == bad) begin
        o2[0]  = o2[0] ^ bad_mask[0];
        o2[DW] = o2[DW] ^ bad_mask[1];
      end
      drive_dut(1'b1, t_e1[first + i], o2);
      tick();
    end
    drive_dut(1'b0, '0, '0);
    exp_lane = (n - 1 == bad) ? bad_mask : '0;
    check("mismatch_lane_last", BW'(mismatch_lane), BW'(exp_lane));
    check("mismatch_last", BW'(mismatch), BW'(exp_lane != '0));
    check("gold_valid_after", BW'(gold_valid), BW'(0));
  endtask

  initial begin
    //       idx op     a0 b0 w0  a1 b1 w1   o1_0 o2_0 o1_1 o2_1
    load(0, 2'b00,  3, 5, 2,  7, 4, 3,   13, 10,  2, 12);
    load(1, 2'b01,  3, 5, 2,  7, 4, 3,    8,  4, 11,  8);
    load(2, 2'b10,  4, 5, 2,  6, 7, 3,    3,  0,  8,  0);
    load(3, 2'b11, 10, 3, 2,  2, 16, 3,  13, 10,  1, 14);
    load(4, 2'b00,  0, 1, 2,  5, 3, 1,    1, 16, 15, 12);  // R_1 = 9

    rstn = 1'b0;
    en   = 1'b1;
    clr  = 1'b0;
    p    = DW'(17);
    R_1  = DW'(1);
    idle_in();
    drive_dut(1'b0, '0, '0);
    repeat (3) tick();

    check("rst_gold_valid", BW'(gold_valid), BW'(0));
    check("rst_gold_out1", gold_out1, BW'(0));
    check("rst_gold_out2", gold_out2, BW'(0));
    check("rst_mismatch", BW'(mismatch), BW'(0));
    check("rst_proto_err", BW'(proto_err), BW'(0));
    check("rst_chk_cnt", BW'(chk_cnt), BW'(0));
    check("rst_err_cnt", BW'(err_cnt), BW'(0));
    check("rst_first_err_idx", BW'(first_err_idx), BW'(0));

    rstn = 1'b1;
    tick();

    // Single CT, then GS/MM/AS back to back
    burst(0, 1, -1, '0);
    check("ct_chk_cnt", BW'(chk_cnt), BW'(1));
    check("ct_err_cnt", BW'(err_cnt), BW'(0));
    burst(1, 3, -1, '0);
    check("b2b_chk_cnt", BW'(chk_cnt), BW'(4));
    check("b2b_err_cnt", BW'(err_cnt), BW'(0));

    // Montgomery factor R_1 = 9
    R_1 = DW'(9);
    burst(4, 1, -1, '0);
    R_1 = DW'(1);
    check("mont_chk_cnt", BW'(chk_cnt), BW'(5));

    // Error on lane 1 of the 3rd transaction, then a second error
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_chk_cnt", BW'(chk_cnt), BW'(0));
    burst(0, 4, 2, 2'b10);
    check("err1_err_cnt", BW'(err_cnt), BW'(1));
    check("err1_chk_cnt", BW'(chk_cnt), BW'(4));
    check("err1_first_idx", BW'(first_err_idx), BW'(2));
    check("err1_first_op", BW'(first_err_op), BW'(2));
    burst(0, 2, 0, 2'b01);
    check("err2_err_cnt", BW'(err_cnt), BW'(2));
    check("err2_chk_cnt", BW'(chk_cnt), BW'(6));
    check("err2_first_idx", BW'(first_err_idx), BW'(2));
    check("err2_first_op", BW'(first_err_op), BW'(2));

    // Stall for 5 cycles in flight, then stall while the result is showing
    drive_in(3);
    tick();
    idle_in();
    repeat (2) tick();
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    repeat (4) tick();
    check("stall_not_early", BW'(gold_valid), BW'(0));
    tick();
    check("stall_gold_valid", BW'(gold_valid), BW'(1));
    check("stall_gold_out1", gold_out1, t_e1[3]);
    en = 1'b0;
    drive_dut(1'b1, '0, '0);
    repeat (3) tick();
    check("hold_gold_valid", BW'(gold_valid), BW'(1));
    check("hold_gold_out2", gold_out2, t_e2[3]);
    check("hold_chk_cnt", BW'(chk_cnt), BW'(6));
    check("hold_mismatch", BW'(mismatch), BW'(0));
    check("hold_proto_err", BW'(proto_err), BW'(0));
    en = 1'b1;
    drive_dut(1'b1, t_e1[3], t_e2[3]);
    tick();
    drive_dut(1'b0, '0, '0);
    check("resume_chk_cnt", BW'(chk_cnt), BW'(7));
    check("resume_err_cnt", BW'(err_cnt), BW'(2));
    check("resume_mismatch", BW'(mismatch), BW'(0));
    check("resume_gold_valid", BW'(gold_valid), BW'(0));

    // dut_valid one cycle early
    drive_in(0);
    tick();
    idle_in();
    repeat (6) tick();
    drive_dut(1'b1, t_e1[0], t_e2[0]);
    tick();
    check("proto_set", BW'(proto_err), BW'(1));
    check("proto_gold_valid", BW'(gold_valid), BW'(1));
    drive_dut(1'b0, '0, '0);
    tick();
    check("proto_no_cmp", BW'(chk_cnt), BW'(7));
    check("proto_no_mismatch", BW'(mismatch), BW'(0));
    repeat (3) tick();
    check("proto_sticky", BW'(proto_err), BW'(1));

    // clr coinciding with a failing compare
    drive_in(2);
    tick();
    idle_in();
    repeat (LATENCY - 1) tick();
    check("clrcmp_gold_valid", BW'(gold_valid), BW'(1));
    drive_dut(1'b1, t_e1[2] ^ BW'(1), t_e2[2]);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    drive_dut(1'b0, '0, '0);
    check("clrcmp_mismatch", BW'(mismatch), BW'(1));
    check("clrcmp_lane", BW'(mismatch_lane), BW'(2'b01));
    check("clrcmp_chk_cnt", BW'(chk_cnt), BW'(0));
    check("clrcmp_err_cnt", BW'(err_cnt), BW'(0));
    check("clrcmp_first_idx", BW'(first_err_idx), BW'(0));
    check("clrcmp_first_op", BW'(first_err_op), BW'(0));
    check("clrcmp_proto", BW'(proto_err), BW'(0));
    tick();
    check("clrcmp_pulse_end", BW'(mismatch), BW'(0));

    // Reset with four transactions in flight
    for (int i = 0; i < 4; i++) begin
      drive_in(i);
      tick();
    end
    idle_in();
    repeat (2) tick();
    rstn = 1'b0;
    tick();
    check("midrst_gold_valid", BW'(gold_valid), BW'(0));
    check("midrst_chk_cnt", BW'(chk_cnt), BW'(0));
    rstn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("midrst_flushed", BW'(gold_valid), BW'(0));
    end

    // 20 failing compares saturate both 4-bit counters
    for (int k = 0; k < 28; k++) begin
      if (k < 20) drive_in(3);
      else idle_in();
      if (k >= 8) drive_dut(1'b1, '0, '0);
      else drive_dut(1'b0, '0, '0);
      tick();
    end
    drive_dut(1'b0, '0, '0);
    idle_in();
    check("sat_chk_cnt", BW'(chk_cnt), BW'(15));
    check("sat_err_cnt", BW'(err_cnt), BW'(15));
    check("sat_first_idx", BW'(first_err_idx), BW'(0));
    check("sat_first_op", BW'(first_err_op), BW'(3));
    check("sat_proto", BW'(proto_err), BW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
